// File: rtl/exponent_calc_pkg.sv
// Shared widths and FSM encoding for the sequential integer power unit.
package exponent_pkg;

  localparam int XW = 4;
  localparam int PW = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/exponent_calc_if.sv
// Operand/strobe and result bundle between a register wrapper and the power unit.
interface exponent_calc_if;
  import exponent_pkg::*;

  logic          i_load;
  logic          i_start;
  logic [XW-1:0] i_X;
  logic [XW-1:0] i_A;
  logic          o_done;
  logic [PW-1:0] o_P;

  modport master (
    output i_load, i_start, i_X, i_A,
    input  o_done, o_P
  );

  modport slave (
    input  i_load, i_start, i_X, i_A,
    output o_done, o_P
  );
endinterface

// File: rtl/exponent_calc.sv
// Computes P = X^A mod 2^PW by repeated multiplication, one multiply per clock.
module exponent_calc
  import exponent_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  exponent_calc_if.slave bus
);

  localparam logic [PW-1:0] ONE_P = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [XW-1:0] ONE_X = {{(XW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [XW-1:0] a_q, a_d;
  logic [XW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] p_q, p_d;
  logic          done_q, done_d;

  // Product kept at PW bits: the multiply itself wraps modulo 2^PW.
  function automatic logic [PW-1:0] mul_trunc(input logic [PW-1:0] p,
                                              input logic [XW-1:0] x);
    logic [PW-1:0] xe;
    xe = {{(PW-XW){1'b0}}, x};
    return p * xe;
  endfunction

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (bus.i_load) begin
          x_d = bus.i_X;
          a_d = bus.i_A;
        end else if (bus.i_start) begin
          p_d     = ONE_P;
          cnt_d   = a_q;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          p_d   = mul_trunc(p_q, x_q);
          cnt_d = cnt_q - ONE_X;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_load) begin
          x_d     = bus.i_X;
          a_d     = bus.i_A;
          done_d  = 1'b0;
          state_d = IDLE;
        end else if (bus.i_start) begin
          done_d  = 1'b0;
          p_d     = ONE_P;
          cnt_d   = a_q;
          state_d = CALC;
        end
      end
      default: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_done = done_q;
  assign bus.o_P    = p_q;

endmodule

// File: tb/tb_exponent_calc.sv
// Scoreboard bench for exponent_calc: directed corner cases plus randomized operands.
module tb_exponent_calc;
  import exponent_pkg::*;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  exponent_calc_if bus();

  exponent_calc dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned p;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  logic [XW-1:0] mx = '0;
  logic [XW-1:0] ma = '0;

  function automatic int unsigned ref_pow(int unsigned x, int unsigned a);
    longint unsigned r = 1;
    for (int i = 0; i < int'(a); i++) r = r * longint'(x);
    return int'(r % (64'd1 << PW));
  endfunction

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, req);
    end
  endtask

  // Monitor: every rising edge of o_done must match the oldest expectation.
  logic prev_done = 1'b0;
  always @(negedge i_clk) begin
    if (bus.o_done && !prev_done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done P=%0d at cycle %0d", bus.o_P, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checks++;
        if (int'(bus.o_P) != int'(e.p)) begin
          errors++;
          $display("FAIL result got %0d expected %0d", bus.o_P, e.p);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL latency done at cycle %0d expected %0d", cyc, e.due);
        end
      end
    end
    prev_done = bus.o_done;
  end

  task automatic strobe(bit ld, bit st, logic [XW-1:0] x, logic [XW-1:0] a);
    bus.i_load  = ld;
    bus.i_start = st;
    bus.i_X     = x;
    bus.i_A     = a;
    @(negedge i_clk);
    bus.i_load  = 1'b0;
    bus.i_start = 1'b0;
  endtask

  task automatic do_load(logic [XW-1:0] x, logic [XW-1:0] a);
    mx = x;
    ma = a;
    strobe(1'b1, 1'b0, x, a);
  endtask

  task automatic do_start();
    exp_t e;
    e.p   = ref_pow(int'(mx), int'(ma));
    e.due = cyc + int'(ma) + 2;
    sbq.push_back(e);
    strobe(1'b0, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15));
  endtask

  task automatic wait_done(int maxc);
    int n = 0;
    while (!bus.o_done && n < maxc) begin
      @(negedge i_clk);
      n++;
    end
    if (!bus.o_done) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for done after %0d cycles", maxc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_load  = 1'b0;
    bus.i_start = 1'b0;
    bus.i_X     = '0;
    bus.i_A     = '0;
    repeat (3) @(negedge i_clk);
    chk("reset_done", int'(bus.o_done), 0);
    chk("reset_p", int'(bus.o_P), 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    do_load(4'd2, 4'd3);
    do_start();
    wait_done(40);
    chk("t1_p", int'(bus.o_P), 8);

    do_start();
    chk("t2_done_drop", int'(bus.o_done), 0);
    wait_done(40);
    chk("t2_p", int'(bus.o_P), 8);

    do_load(4'd3, 4'd0);
    do_start();
    wait_done(5);
    chk("t3_a0", int'(bus.o_P), 1);
    do_load(4'd0, 4'd5);
    do_start();
    wait_done(40);
    chk("t3_x0", int'(bus.o_P), 0);

    do_load(4'd2, 4'd15);
    do_start();
    wait_done(40);
    chk("t4_wrap0", int'(bus.o_P), 0);
    do_load(4'd15, 4'd4);
    do_start();
    wait_done(40);
    chk("t4_wrap", int'(bus.o_P), 17857);

    // Strobes during CALC must not disturb the running computation or operands.
    do_load(4'd3, 4'd5);
    do_start();
    strobe(1'b1, 1'b1, 4'd7, 4'd2);
    strobe(1'b0, 1'b1, 4'd7, 4'd2);
    wait_done(40);
    chk("t5_calc_ignore", int'(bus.o_P), 243);
    do_start();
    wait_done(40);
    chk("t5_operands_kept", int'(bus.o_P), 243);

    mx = 4'd6; ma = 4'd2;
    strobe(1'b1, 1'b1, 4'd6, 4'd2);
    chk("t5_done_load_wins", int'(bus.o_done), 0);
    repeat (6) @(negedge i_clk);
    chk("t5_no_start_done", int'(bus.o_done), 0);
    do_start();
    wait_done(40);
    chk("t5_after_done_load", int'(bus.o_P), 36);

    do_load(4'd1, 4'd1);
    mx = 4'd5; ma = 4'd3;
    strobe(1'b1, 1'b1, 4'd5, 4'd3);
    repeat (8) @(negedge i_clk);
    chk("t5_idle_load_wins", int'(bus.o_done), 0);
    do_start();
    wait_done(40);
    chk("t5_idle_loaded", int'(bus.o_P), 125);

    // Reset mid-computation clears everything including the operand registers.
    do_load(4'd3, 4'd15);
    do_start();
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("t6_rst_done", int'(bus.o_done), 0);
    chk("t6_rst_p", int'(bus.o_P), 0);
    i_rst_n = 1'b1;
    void'(sbq.pop_back());
    mx = '0; ma = '0;
    repeat (20) @(negedge i_clk);
    chk("t6_idle_after_rst", int'(bus.o_done), 0);
    do_start();
    wait_done(5);
    chk("t6_zero_pow_zero", int'(bus.o_P), 1);
    do_load(4'd5, 4'd2);
    do_start();
    wait_done(40);
    chk("t6_after_rst", int'(bus.o_P), 25);

    for (int i = 0; i < 40; i++) begin
      do_load(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      do_start();
      wait_done(40);
      if ($urandom_range(0, 2) == 0) begin
        do_start();
        wait_done(40);
      end
    end

    repeat (3) @(negedge i_clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
